usd_data_rx: RTL

Parametrised multi-block read receiver for the micro SD data lines. It sits between the data-pad input buffers and the read-data FIFO, replacing the fixed 4-bit single-mode read path. It adds 1/4/8-lane bus width, multi-block reads, per-lane CRC16 checking, start-bit timeout, and card-clock hold at block boundaries when the FIFO is nearly full.

---
 rtl/usd_data_rx.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/usd_data_rx.sv
// usd_data_rx: multi-block micro SD read receiver with 1/4/8 lanes, start-bit timeout and
// card-clock hold between blocks. Define USD_RX_CRC_EN to build the per-lane CRC16 check.
module usd_data_rx #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned WORD_W      = 64,
  parameter int unsigned BLK_BYTES   = 512,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              sdClk,
  input  logic              sysRst,
  input  logic              readCmd,
  input  logic [15:0]       blockCount,
  input  logic              abort,
  input  logic [LANES-1:0]  sdDataIn,
  input  logic              readFifoAlmostFull,
  output logic [WORD_W-1:0] readDataOut,
  output logic              readFifoWe,
  output logic              sdClkEn,
  output logic              busy,
  output logic              readDone,
  output logic              crcErr,
  output logic              timeOut,
  output logic [15:0]       blocksDone
);

  localparam int unsigned DataCyc = (BLK_BYTES * 8) / LANES;
  localparam int unsigned WordCyc = WORD_W / LANES;
  localparam int unsigned BitW    = $clog2(DataCyc + 1);
  localparam int unsigned WcW     = $clog2(WordCyc + 1);
  localparam int unsigned ToW     = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    StIdle, StWaitStart, StData, StCrc, StEnd, StHold
  } state_e;

  state_e stateQ, stateD;

  logic [15:0]       countQ, countD;
  logic [15:0]       blocksQ, blocksD;
  logic [BitW-1:0]   bitCntQ, bitCntD;
  logic [WcW-1:0]    wordCntQ, wordCntD;
  logic [3:0]        crcCntQ, crcCntD;
  logic [ToW-1:0]    toCntQ, toCntD;
  logic [WORD_W-1:0] packQ, packD;
  logic [WORD_W-1:0] dataQ, dataD;
  logic              weQ, weD;
  logic              clkEnQ, clkEnD;
  logic              busyQ, busyD;
  logic              doneQ, doneD;
  logic              crcErrQ, crcErrD;
  logic              toQ, toD;

  logic              cmdGo, startBit, toExpire, lastData, wordEnd, crcLast;
  logic              blockBad, endOk, lastBlock;
  logic [15:0]       blocksInc;
  logic [WORD_W-1:0] packNext;

  // Abort takes priority over a coincident read command.
  assign cmdGo     = readCmd & ~abort;
  assign startBit  = ~|sdDataIn;
  assign toExpire  = (toCntQ == ToW'(TIMEOUT_CYC - 1));
  assign lastData  = (bitCntQ == BitW'(DataCyc - 1));
  assign wordEnd   = (wordCntQ == WcW'(WordCyc - 1));
  assign crcLast   = (crcCntQ == 4'd15);
  assign endOk     = (&sdDataIn) & ~blockBad;
  assign blocksInc = blocksQ + 16'd1;
  assign lastBlock = (blocksInc == countQ);
  // Lane LANES-1 lands in the most significant position of each shifted group.
  assign packNext  = (packQ << LANES) | WORD_W'(sdDataIn);

`ifdef USD_RX_CRC_EN
  logic [LANES-1:0][15:0] crcQ, crcD;
  logic                   crcBadQ, crcBadD;

  function automatic logic [15:0] crc16Step(input logic [15:0] crc, input logic bitIn);
    logic fb;
    fb = bitIn ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  always_comb begin
    crcD    = crcQ;
    crcBadD = crcBadQ;
    unique case (stateQ)
      StWaitStart: begin
        crcD    = '0;
        crcBadD = 1'b0;
      end
      StData: begin
        for (int l = 0; l < LANES; l++) crcD[l] = crc16Step(crcQ[l], sdDataIn[l]);
      end
      // Received CRC arrives MSB first; shift the running value out alongside it.
      StCrc: begin
        for (int l = 0; l < LANES; l++) begin
          if (sdDataIn[l] != crcQ[l][15]) crcBadD = 1'b1;
          crcD[l] = {crcQ[l][14:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sdClk or posedge sysRst) begin
    if (sysRst) begin
      crcQ    <= '0;
      crcBadQ <= 1'b0;
    end else begin
      crcQ    <= crcD;
      crcBadQ <= crcBadD;
    end
  end

  assign blockBad = crcBadQ;
`else
  assign blockBad = 1'b0;
`endif

  always_ff @(posedge sdClk or posedge sysRst) begin
    if (sysRst) stateQ <= StIdle;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:      if (cmdGo && blockCount != 16'd0) stateD = StWaitStart;
      StWaitStart: begin
        if (startBit)      stateD = StData;
        else if (toExpire) stateD = StIdle;
      end
      StData:      if (lastData) stateD = StCrc;
      StCrc:       if (crcLast) stateD = StEnd;
      StEnd:       stateD = (!endOk || lastBlock) ? StIdle : StHold;
      StHold:      if (!readFifoAlmostFull) stateD = StWaitStart;
      default:     stateD = StIdle;
    endcase
    if (abort) stateD = StIdle;
  end

  always_comb begin
    countD   = countQ;
    blocksD  = blocksQ;
    bitCntD  = bitCntQ;
    wordCntD = wordCntQ;
    crcCntD  = crcCntQ;
    toCntD   = toCntQ;
    packD    = packQ;
    dataD    = dataQ;
    weD      = 1'b0;
    clkEnD   = clkEnQ;
    busyD    = busyQ;
    doneD    = 1'b0;
    crcErrD  = crcErrQ;
    toD      = toQ;
    unique case (stateQ)
      StIdle: begin
        if (cmdGo) begin
          countD  = blockCount;
          crcErrD = 1'b0;
          toD     = 1'b0;
          blocksD = 16'd0;
          toCntD  = '0;
          if (blockCount == 16'd0) doneD = 1'b1;
          else                     busyD = 1'b1;
        end
      end
      StWaitStart: begin
        if (startBit) begin
          bitCntD  = '0;
          wordCntD = '0;
          crcCntD  = '0;
          toCntD   = '0;
        end else if (toExpire) begin
          toD   = 1'b1;
          doneD = 1'b1;
          busyD = 1'b0;
        end else begin
          toCntD = toCntQ + ToW'(1);
        end
      end
      StData: begin
        packD   = packNext;
        bitCntD = bitCntQ + BitW'(1);
        if (wordEnd) begin
          dataD    = packNext;
          weD      = 1'b1;
          wordCntD = '0;
        end else begin
          wordCntD = wordCntQ + WcW'(1);
        end
        if (lastData) crcCntD = '0;
      end
      StCrc: crcCntD = crcCntQ + 4'd1;
      StEnd: begin
        if (endOk) begin
          blocksD = blocksInc;
          if (lastBlock) begin
            doneD = 1'b1;
            busyD = 1'b0;
          end
        end else begin
          crcErrD = 1'b1;
          doneD   = 1'b1;
          busyD   = 1'b0;
        end
      end
      StHold: begin
        if (readFifoAlmostFull) begin
          clkEnD = 1'b0;
        end else begin
          clkEnD = 1'b1;
          toCntD = '0;
        end
      end
      default: ;
    endcase
    if (abort) begin
      busyD  = 1'b0;
      doneD  = 1'b0;
      weD    = 1'b0;
      clkEnD = 1'b1;
    end
  end

  always_ff @(posedge sdClk or posedge sysRst) begin
    if (sysRst) begin
      countQ   <= '0;
      blocksQ  <= '0;
      bitCntQ  <= '0;
      wordCntQ <= '0;
      crcCntQ  <= '0;
      toCntQ   <= '0;
      packQ    <= '0;
      dataQ    <= '0;
      weQ      <= 1'b0;
      clkEnQ   <= 1'b1;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      crcErrQ  <= 1'b0;
      toQ      <= 1'b0;
    end else begin
      countQ   <= countD;
      blocksQ  <= blocksD;
      bitCntQ  <= bitCntD;
      wordCntQ <= wordCntD;
      crcCntQ  <= crcCntD;
      toCntQ   <= toCntD;
      packQ    <= packD;
      dataQ    <= dataD;
      weQ      <= weD;
      clkEnQ   <= clkEnD;
      busyQ    <= busyD;
      doneQ    <= doneD;
      crcErrQ  <= crcErrD;
      toQ      <= toD;
    end
  end

  assign readDataOut = dataQ;
  assign readFifoWe  = weQ;
  assign sdClkEn     = clkEnQ;
  assign busy        = busyQ;
  assign readDone    = doneQ;
  assign crcErr      = crcErrQ;
  assign timeOut     = toQ;
  assign blocksDone  = blocksQ;

endmodule
